// File: rtl/uart_alu_interface.sv
// UART-to-ALU frame sequencer: collects A, B and opcode bytes, then sends the result.
// Optional inter-byte timeout enabled by defining UART_ALU_TIMEOUT_EN.
module uart_alu_interface #(
   parameter int DATA_WIDTH     = 8,
   parameter int OP_CODE_SIZE   = 6,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [DATA_WIDTH-1:0]   i_rx_data,
   input  logic                    i_rx_done,
   output logic [DATA_WIDTH-1:0]   o_dato_a,
   output logic [DATA_WIDTH-1:0]   o_dato_b,
   output logic [OP_CODE_SIZE-1:0] o_op_code,
   input  logic [DATA_WIDTH-1:0]   i_resultado,
   output logic [DATA_WIDTH-1:0]   o_tx_data,
   output logic                    o_tx_start,
   input  logic                    i_tx_done,
   output logic                    o_busy,
   output logic                    o_frame_err
);

   typedef enum logic [2:0] {
      WAIT_A  = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      SEND    = 3'd3,
      WAIT_TX = 3'd4
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [DATA_WIDTH-1:0]   r_dato_a;
   logic [DATA_WIDTH-1:0]   r_dato_b;
   logic [OP_CODE_SIZE-1:0] r_op_code;
   logic [DATA_WIDTH-1:0]   r_tx_data;
   logic                    r_tx_start;
   logic                    w_timeout;
   logic                    w_cap_a;
   logic                    w_cap_b;
   logic                    w_cap_op;
   logic                    w_send;
   logic                    w_busy;

`ifdef UART_ALU_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [CNT_W-1:0] r_cnt;
   logic             r_frame_err;
   logic             w_in_wait;

   assign w_in_wait = (r_state == WAIT_B) || (r_state == WAIT_OP);
   assign w_timeout = w_in_wait && !i_rx_done &&
                      (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Inter-byte idle counter, restarted by every received byte
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)
         r_cnt <= '0;
      else if (i_rx_done || !w_in_wait || w_timeout)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + 1'b1;
   end

   // One-cycle abort pulse when a partial frame times out
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)
         r_frame_err <= 1'b0;
      else
         r_frame_err <= w_timeout;
   end

   assign o_frame_err = r_frame_err;
`else
   assign w_timeout   = 1'b0;
   assign o_frame_err = 1'b0;
`endif

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)
         r_state <= WAIT_A;
      else
         r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         WAIT_A:  if (i_rx_done) w_next = WAIT_B;
         WAIT_B:  if (i_rx_done) w_next = WAIT_OP;
                  else if (w_timeout) w_next = WAIT_A;
         WAIT_OP: if (i_rx_done) w_next = SEND;
                  else if (w_timeout) w_next = WAIT_A;
         SEND:    w_next = WAIT_TX;
         WAIT_TX: if (i_tx_done) w_next = WAIT_A;
         default: w_next = WAIT_A;
      endcase
   end

   // Output decode: capture strobes, send strobe and busy flag
   always_comb begin
      w_cap_a  = 1'b0;
      w_cap_b  = 1'b0;
      w_cap_op = 1'b0;
      w_send   = 1'b0;
      w_busy   = 1'b0;
      case (r_state)
         WAIT_A:  w_cap_a  = i_rx_done;
         WAIT_B:  w_cap_b  = i_rx_done;
         WAIT_OP: w_cap_op = i_rx_done;
         SEND: begin
            w_send = 1'b1;
            w_busy = 1'b1;
         end
         WAIT_TX: w_busy = 1'b1;
         default: w_busy = 1'b0;
      endcase
   end

   // Operand/opcode capture; values persist between frames
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_dato_a  <= '0;
         r_dato_b  <= '0;
         r_op_code <= '0;
      end else begin
         if (w_cap_a)  r_dato_a  <= i_rx_data;
         if (w_cap_b)  r_dato_b  <= i_rx_data;
         if (w_cap_op) r_op_code <= i_rx_data[OP_CODE_SIZE-1:0];
      end
   end

   // Result latch and transmitter start pulse
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_tx_data  <= '0;
         r_tx_start <= 1'b0;
      end else begin
         r_tx_start <= w_send;
         if (w_send) r_tx_data <= i_resultado;
      end
   end

   assign o_dato_a   = r_dato_a;
   assign o_dato_b   = r_dato_b;
   assign o_op_code  = r_op_code;
   assign o_tx_data  = r_tx_data;
   assign o_tx_start = r_tx_start;
   assign o_busy     = w_busy;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface with a small combinational ALU.
// Timeout scenario follows UART_ALU_TIMEOUT_EN.
module tb_uart_alu_interface;

   logic       clk;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_done;
   logic [7:0] dato_a;
   logic [7:0] dato_b;
   logic [5:0] op_code;
   logic [7:0] resultado;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_done;
   logic       busy;
   logic       frame_err;

   int n_cmp = 0;
   int n_err = 0;

   uart_alu_interface #(
      .DATA_WIDTH(8),
      .OP_CODE_SIZE(6),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_rx_data(rx_data),
      .i_rx_done(rx_done),
      .o_dato_a(dato_a),
      .o_dato_b(dato_b),
      .o_op_code(op_code),
      .i_resultado(resultado),
      .o_tx_data(tx_data),
      .o_tx_start(tx_start),
      .i_tx_done(tx_done),
      .o_busy(busy),
      .o_frame_err(frame_err)
   );

   // Team ALU
   always_comb begin
      resultado = 8'h00;
      case (op_code)
         6'h20: resultado = dato_a + dato_b;
         6'h22: resultado = dato_a - dato_b;
         6'h24: resultado = dato_a & dato_b;
         6'h25: resultado = dato_a | dato_b;
         6'h26: resultado = dato_a ^ dato_b;
         6'h27: resultado = ~(dato_a | dato_b);
         6'h03: resultado = $signed(dato_a) >>> dato_b;
         6'h02: resultado = dato_a >> dato_b;
         default: resultado = 8'h00;
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
   endtask

   task automatic pulse_tx_done();
      @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
   endtask

   // Opcode byte goes last; checks the N+2 start pulse and the result
   task automatic frame(input string tag, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] op,
                        input logic [7:0] res);
      send_byte(a);
      send_byte(b);
      send_byte(op);
      check({tag, "_start_n1"}, tx_start, 0);
      check({tag, "_busy_n1"}, busy, 1);
      @(negedge clk);
      check({tag, "_start_n2"}, tx_start, 1);
      check({tag, "_txdata"}, tx_data, res);
      @(negedge clk);
      check({tag, "_start_off"}, tx_start, 0);
      check({tag, "_busy_wait"}, busy, 1);
   endtask

   initial begin
      logic saw_err;
      rst_n   = 1'b0;
      rx_data = 8'h00;
      rx_done = 1'b0;
      tx_done = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_a", dato_a, 0);
      check("rst_b", dato_b, 0);
      check("rst_op", op_code, 0);
      check("rst_tx", tx_data, 0);
      check("rst_start", tx_start, 0);
      check("rst_busy", busy, 0);
      check("rst_ferr", frame_err, 0);
      rst_n = 1'b1;

      // stray tx_done while idle must not disturb anything
      pulse_tx_done();
      check("stray_txd_busy", busy, 0);

      // basic add
      frame("basic", 8'h05, 8'h03, 8'h20, 8'h08);
      pulse_tx_done();
      check("basic_busy_end", busy, 0);
      check("basic_hold", tx_data, 8'h08);

      // opcode upper bits dropped: 0xE7 -> 0x27 NOR
      frame("mask", 8'hF0, 8'h0F, 8'hE7, 8'h00);
      check("mask_op", op_code, 6'h27);
      pulse_tx_done();

      // bytes during transmit are dropped
      frame("dropA", 8'h0A, 8'h04, 8'h22, 8'h06);
      send_byte(8'h99);
      check("drop_busy", busy, 1);
      check("drop_a", dato_a, 8'h0A);
      @(negedge clk);
      rx_data = 8'h55;
      rx_done = 1'b1;
      tx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      tx_done = 1'b0;
      check("coinc_busy", busy, 0);
      check("coinc_a", dato_a, 8'h0A);
      check("coinc_hold", tx_data, 8'h06);
      frame("dropB", 8'h01, 8'h01, 8'h20, 8'h02);
      pulse_tx_done();

      // reset in the middle of a frame
      send_byte(8'h11);
      send_byte(8'h22);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("mrst_a", dato_a, 0);
      check("mrst_b", dato_b, 0);
      check("mrst_op", op_code, 0);
      check("mrst_tx", tx_data, 0);
      check("mrst_busy", busy, 0);
      check("mrst_start", tx_start, 0);
      check("mrst_ferr", frame_err, 0);
      rst_n = 1'b1;
      frame("mrst", 8'h03, 8'h04, 8'h24, 8'h00);
      check("mrst_newa", dato_a, 8'h03);
      check("mrst_newb", dato_b, 8'h04);
      pulse_tx_done();

`ifdef UART_ALU_TIMEOUT_EN
      send_byte(8'h07);
      repeat (15) @(negedge clk);
      check("to_pre", frame_err, 0);
      @(negedge clk);
      check("to_pulse", frame_err, 1);
      check("to_busy", busy, 0);
      @(negedge clk);
      check("to_pulse_end", frame_err, 0);
      check("to_keep_a", dato_a, 8'h07);
      frame("to_next", 8'h02, 8'h02, 8'h20, 8'h04);
      check("to_next_a", dato_a, 8'h02);
      pulse_tx_done();
`else
      send_byte(8'h07);
      saw_err = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (frame_err !== 1'b0) saw_err = 1'b1;
      end
      send_byte(8'h01);
      send_byte(8'h20);
      check("nto_start_n1", tx_start, 0);
      @(negedge clk);
      check("nto_start_n2", tx_start, 1);
      check("nto_txdata", tx_data, 8'h08);
      check("nto_ferr", saw_err, 0);
      pulse_tx_done();
      check("nto_busy_end", busy, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
